// File: rtl/uart_byte_link.sv
// 8N1 UART transceiver: independent receive and transmit paths sharing one clock.
// The receiver resynchronises uart_rxd and samples at bit midpoints; the transmitter sends one latched byte per request.
module uart_byte_link #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic       uart_done,
    output logic [7:0] uart_data_out,
    input  logic       uart_en,
    input  logic [7:0] uart_data_in,
    output logic       tx_busy,
    output logic       frame_err
);

    localparam int BPS_CNT   = CLK_FREQ / UART_BPS;
    localparam int HALF_CNT  = BPS_CNT / 2;
    // The synchronizer delays rxd by two cycles, so the start check comes that much earlier.
    localparam int START_OFF = (HALF_CNT > 2) ? HALF_CNT - 2 : 0;
    localparam int CNT_W     = $clog2(BPS_CNT + 1);
    localparam logic [CNT_W-1:0] C_BIT_LAST   = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] C_START_LAST = CNT_W'(START_OFF);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic {T_IDLE, T_SEND} tx_state_t;

    rx_state_t        r_rx_state;
    rx_state_t        w_rx_next;
    logic             r_rx_s1;
    logic             r_rx_s2;
    logic             r_rx_d;
    logic [2:0]       r_rx_vld;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [3:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_done;
    logic             r_rx_err;
    logic             w_rx_fall;
    logic             w_rx_bit_end;
    logic             w_rx_start_mid;

    tx_state_t        r_tx_state;
    tx_state_t        w_tx_next;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [3:0]       r_tx_bit;
    logic [9:0]       r_tx_frame;
    logic             r_txd;
    logic             r_tx_hold;
    logic             w_tx_start;
    logic             w_tx_bit_end;

    // r_rx_vld marks when r_rx_d holds a real pin sample, so a line low out of reset is never an edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_s1  <= 1'b1;
            r_rx_s2  <= 1'b1;
            r_rx_d   <= 1'b1;
            r_rx_vld <= 3'b000;
        end else begin
            r_rx_s1  <= uart_rxd;
            r_rx_s2  <= r_rx_s1;
            r_rx_d   <= r_rx_s2;
            r_rx_vld <= {r_rx_vld[1:0], 1'b1};
        end
    end

    assign w_rx_fall      = r_rx_vld[2] & r_rx_d & ~r_rx_s2;
    assign w_rx_bit_end   = (r_rx_cnt == C_BIT_LAST);
    assign w_rx_start_mid = (r_rx_cnt == C_START_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_rx_state <= R_IDLE;
        else            r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            R_IDLE:  if (w_rx_fall) w_rx_next = R_START;
            R_START: if (w_rx_start_mid) w_rx_next = r_rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (w_rx_bit_end && r_rx_bit == 4'd7) w_rx_next = R_STOP;
            R_STOP:  if (w_rx_bit_end) w_rx_next = R_IDLE;
            default: w_rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= 4'd0;
            r_rx_shift <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rx_done  <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            r_rx_err  <= 1'b0;
            case (r_rx_state)
                R_IDLE: begin
                    r_rx_cnt <= '0;
                    r_rx_bit <= 4'd0;
                end
                R_START: r_rx_cnt <= w_rx_start_mid ? '0 : r_rx_cnt + 1'b1;
                R_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt <= '0;
                        if (r_rx_s2) begin
                            r_rx_data <= r_rx_shift;
                            r_rx_done <= 1'b1;
                        end else begin
                            r_rx_err <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_cnt <= '0;
            endcase
        end
    end

    assign uart_done     = r_rx_done;
    assign frame_err     = r_rx_err;
    assign uart_data_out = r_rx_data;

    // A request must drop before it can start another frame, so a held uart_en sends once.
    assign w_tx_start   = (r_tx_state == T_IDLE) & uart_en & ~r_tx_hold;
    assign w_tx_bit_end = (r_tx_cnt == C_BIT_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_tx_state <= T_IDLE;
        else            r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            T_IDLE:  if (w_tx_start) w_tx_next = T_SEND;
            T_SEND:  if (w_tx_bit_end && r_tx_bit == 4'd9) w_tx_next = T_IDLE;
            default: w_tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= 4'd0;
            r_tx_frame <= 10'h3FF;
            r_txd      <= 1'b1;
            r_tx_hold  <= 1'b0;
        end else begin
            r_tx_hold <= uart_en & (r_tx_hold | w_tx_start);
            case (r_tx_state)
                T_IDLE: begin
                    r_tx_cnt <= '0;
                    r_tx_bit <= 4'd0;
                    if (w_tx_start) begin
                        r_tx_frame <= {1'b1, uart_data_in, 1'b0};
                        r_txd      <= 1'b0;
                    end else begin
                        r_txd <= 1'b1;
                    end
                end
                T_SEND: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 4'd9) begin
                            r_txd <= 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_txd      <= r_tx_frame[1];
                            r_tx_frame <= {1'b1, r_tx_frame[9:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_txd <= 1'b1;
            endcase
        end
    end

    assign uart_txd = r_txd;
    assign tx_busy  = (r_tx_state == T_SEND);

endmodule

// File: tb/tb_uart_byte_link.sv
// Bench for uart_byte_link at 10 clocks per bit: random bytes through both directions against a frame-level model.
module tb_uart_byte_link;
    localparam int CLK_FREQ = 1000000;
    localparam int UART_BPS = 100000;
    localparam int BPS      = CLK_FREQ / UART_BPS;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       uart_en = 1'b0;
    logic [7:0] uart_data_in = 8'h00;
    logic       uart_txd;
    logic       uart_done;
    logic [7:0] uart_data_out;
    logic       tx_busy;
    logic       frame_err;

    uart_byte_link #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
        .uart_done(uart_done), .uart_data_out(uart_data_out), .uart_en(uart_en),
        .uart_data_in(uart_data_in), .tx_busy(tx_busy), .frame_err(frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = 0;
    logic [7:0] done_data = 8'h00;
    logic [7:0] ref_last = 8'h00;
    logic cap_txd [0:129];
    logic cap_busy [0:129];

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (uart_done === 1'b1) begin
            done_cnt++;
            done_data = uart_data_out;
            done_cyc = cyc;
        end
        if (frame_err === 1'b1) err_cnt++;
    end

    function automatic logic [9:0] frame_of(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    task automatic drive_rx(input logic [7:0] d, input logic stop_v, output int c0);
        @(negedge sys_clk);
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            uart_rxd = (i == 0) ? 1'b0 : (i == 9) ? stop_v : d[i-1];
            repeat (BPS) @(negedge sys_clk);
        end
        uart_rxd = 1'b1;
        repeat (2 * BPS) @(negedge sys_clk);
    endtask

    task automatic tx_capture(input logic [7:0] d, input int en_len, input int second_at, input logic [7:0] d2);
        @(negedge sys_clk);
        uart_en = 1'b1;
        uart_data_in = d;
        for (int j = 0; j < 130; j++) begin
            @(negedge sys_clk);
            cap_txd[j] = uart_txd;
            cap_busy[j] = tx_busy;
            if (j + 1 >= en_len) uart_en = 1'b0;
            if (j == second_at) begin
                uart_en = 1'b1;
                uart_data_in = d2;
            end
        end
        uart_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        n_cmp++; if (uart_txd !== 1'b1) begin n_bad++; $display("FAIL rst_txd got %b want 1", uart_txd); end
        n_cmp++; if (uart_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", uart_done); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", frame_err); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", tx_busy); end
        n_cmp++; if (uart_data_out !== 8'h00) begin n_bad++; $display("FAIL rst_data got %h want 00", uart_data_out); end
        sys_rst_n = 1'b1;
        ref_last = 8'h00;
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic test_rx(input string name, input logic [7:0] d, input logic stop_v);
        int dc, ec, c0;
        dc = done_cnt; ec = err_cnt;
        drive_rx(d, stop_v, c0);
        if (stop_v) ref_last = d;
        n_cmp++; if (done_cnt - dc !== (stop_v ? 1 : 0)) begin n_bad++; $display("FAIL %s done_pulses got %0d want %0d", name, done_cnt - dc, stop_v ? 1 : 0); end
        n_cmp++; if (err_cnt - ec !== (stop_v ? 0 : 1)) begin n_bad++; $display("FAIL %s err_pulses got %0d want %0d", name, err_cnt - ec, stop_v ? 0 : 1); end
        n_cmp++; if (uart_data_out !== ref_last) begin n_bad++; $display("FAIL %s data_out got %h want %h", name, uart_data_out, ref_last); end
        if (stop_v) begin
            n_cmp++; if (done_cyc - c0 < 96 || done_cyc - c0 > 98) begin n_bad++; $display("FAIL %s latency got %0d want 96..98", name, done_cyc - c0); end
            n_cmp++; if (done_data !== d) begin n_bad++; $display("FAIL %s done_data got %h want %h", name, done_data, d); end
        end
    endtask

    task automatic test_tx(input string name, input logic [7:0] d, input int en_len, input int second_at, input logic [7:0] d2);
        logic [9:0] obs;
        int nb;
        tx_capture(d, en_len, second_at, d2);
        nb = 0;
        for (int i = 0; i < 10; i++) obs[i] = cap_txd[10 * i + 5];
        for (int j = 0; j < 130; j++) nb += (cap_busy[j] === 1'b1) ? 1 : 0;
        n_cmp++; if (obs !== frame_of(d)) begin n_bad++; $display("FAIL %s frame got %b want %b", name, obs, frame_of(d)); end
        n_cmp++; if (nb !== 100) begin n_bad++; $display("FAIL %s busy_cycles got %0d want 100", name, nb); end
        n_cmp++; if (cap_busy[0] !== 1'b1 || cap_busy[99] !== 1'b1 || cap_busy[100] !== 1'b0) begin n_bad++; $display("FAIL %s busy_window got %b%b%b want 110", name, cap_busy[0], cap_busy[99], cap_busy[100]); end
        n_cmp++; if (cap_txd[100] !== 1'b1 || cap_txd[129] !== 1'b1) begin n_bad++; $display("FAIL %s txd_after got %b%b want 11", name, cap_txd[100], cap_txd[129]); end
    endtask

    task automatic test_tx_random();
        for (int k = 0; k < 3; k++) test_tx("tx_rand", 8'($urandom), int'($urandom_range(1, 8)), -1, 8'h00);
    endtask

    task automatic test_glitch();
        int dc, ec;
        dc = done_cnt; ec = err_cnt;
        @(negedge sys_clk); uart_rxd = 1'b0;
        repeat (3) @(negedge sys_clk);
        uart_rxd = 1'b1;
        repeat (120) @(negedge sys_clk);
        n_cmp++; if (done_cnt !== dc) begin n_bad++; $display("FAIL glitch_done got %0d want %0d", done_cnt, dc); end
        n_cmp++; if (err_cnt !== ec) begin n_bad++; $display("FAIL glitch_err got %0d want %0d", err_cnt, ec); end
        test_rx("after_glitch", 8'($urandom), 1'b1);
    endtask

    task automatic test_rx_random();
        for (int k = 0; k < 5; k++) test_rx("rx_rand", 8'($urandom), 1'b1);
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 2; k++) begin
            logic [7:0] rd, td;
            logic [9:0] obs;
            int dc, c0;
            rd = 8'($urandom); td = 8'($urandom);
            dc = done_cnt;
            fork
                tx_capture(td, 1, -1, 8'h00);
                drive_rx(rd, 1'b1, c0);
            join
            ref_last = rd;
            for (int i = 0; i < 10; i++) obs[i] = cap_txd[10 * i + 5];
            n_cmp++; if (obs !== frame_of(td)) begin n_bad++; $display("FAIL simul_tx got %b want %b", obs, frame_of(td)); end
            n_cmp++; if (done_cnt - dc !== 1 || uart_data_out !== ref_last) begin n_bad++; $display("FAIL simul_rx got %0d/%h want 1/%h", done_cnt - dc, uart_data_out, ref_last); end
        end
    endtask

    task automatic test_reset_midframe();
        int dc, ec;
        logic [7:0] rb;
        rb = 8'($urandom);
        @(negedge sys_clk);
        uart_en = 1'b1; uart_data_in = 8'hFF; uart_rxd = 1'b0;
        for (int k = 1; k < 50; k++) begin
            @(negedge sys_clk);
            uart_en = 1'b0;
            if (k % 10 == 0) uart_rxd = rb[k / 10 - 1];
        end
        dc = done_cnt; ec = err_cnt;
        n_cmp++; if (tx_busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before got %b want 1", tx_busy); end
        sys_rst_n = 1'b0;
        #1;
        n_cmp++; if (uart_txd !== 1'b1) begin n_bad++; $display("FAIL mid_txd got %b want 1", uart_txd); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", tx_busy); end
        repeat (3) @(negedge sys_clk);
        ref_last = 8'h00;
        n_cmp++; if (uart_data_out !== ref_last) begin n_bad++; $display("FAIL mid_data got %h want %h", uart_data_out, ref_last); end
        uart_rxd = 1'b1;
        @(negedge sys_clk); sys_rst_n = 1'b1;
        repeat (150) @(negedge sys_clk);
        n_cmp++; if (done_cnt !== dc || err_cnt !== ec) begin n_bad++; $display("FAIL mid_pulses got %0d/%0d want %0d/%0d", done_cnt, err_cnt, dc, ec); end
        n_cmp++; if (tx_busy !== 1'b0 || uart_txd !== 1'b1) begin n_bad++; $display("FAIL mid_tx_idle got %b%b want 01", tx_busy, uart_txd); end
        test_rx("after_reset_0F", 8'h0F, 1'b1);
    endtask

    task automatic test_line_low();
        int dc, ec;
        @(negedge sys_clk);
        sys_rst_n = 1'b0; uart_rxd = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        ref_last = 8'h00;
        dc = done_cnt; ec = err_cnt;
        repeat (150) @(negedge sys_clk);
        n_cmp++; if (done_cnt !== dc || err_cnt !== ec) begin n_bad++; $display("FAIL low_pulses got %0d/%0d want %0d/%0d", done_cnt, err_cnt, dc, ec); end
        uart_rxd = 1'b1;
        repeat (20) @(negedge sys_clk);
        test_rx("after_low_A5", 8'hA5, 1'b1);
    endtask

    initial begin
        test_reset();
        test_rx("rx_A5", 8'hA5, 1'b1);
        test_tx("tx_3C", 8'h3C, 1, -1, 8'h00);
        test_glitch();
        test_rx("rx_A5_again", 8'hA5, 1'b1);
        test_rx("rx_5A_badstop", 8'h5A, 1'b0);
        test_tx("tx_11_ignore_22", 8'h11, 1, 39, 8'h22);
        test_tx("tx_held_en", 8'h96, 6, -1, 8'h00);
        test_rx_random();
        test_tx_random();
        test_simultaneous();
        test_reset_midframe();
        test_line_low();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_byte_link.md
UART_BYTE_LINK -- requirements
Module: uart_byte_link

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, sys_clk frequency in Hz, SHALL be honoured.
REQ-002 Parameter UART_BPS, default 115200, line baud rate, SHALL be honoured.
REQ-003 Port sys_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port uart_rxd  input  1  serial line in, asynchronous to sys_clk, idle high.
REQ-006 Port uart_txd  output  1  serial line out, idle high.
REQ-007 Port uart_done  output  1  one-cycle pulse: a valid received byte is on uart_data_out.
REQ-008 Port uart_data_out  output  8  last valid received byte.
REQ-009 Port uart_en  input  1  transmit request, sampled every cycle.
REQ-010 Port uart_data_in  input  8  byte to transmit, sampled with uart_en.
REQ-011 Port tx_busy  output  1  high while a frame is being transmitted.
REQ-012 Port frame_err  output  1  one-cycle pulse: received frame had a low stop bit.

Function
REQ-013 Bit period BPS_CNT SHALL be CLK_FREQ/UART_BPS (integer division, truncated); frame SHALL be 8N1, LSB first.
REQ-014 uart_rxd SHALL pass through a 2-flop synchronizer; RX logic SHALL use only the synchronized value.
REQ-015 RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
REQ-016 R_IDLE -> R_START on a high-to-low transition of the synchronized rxd; bit counter cleared.
REQ-017 R_START: at BPS_CNT/2 cycles, rxd low -> R_DATA; rxd high -> R_IDLE (glitch rejected, no pulse).
REQ-018 R_DATA: sample every BPS_CNT cycles from the start-bit midpoint, shift in LSB first; after 8th bit -> R_STOP.
REQ-019 R_STOP: sample at midpoint; high -> load uart_data_out, pulse uart_done for exactly 1 cycle; low -> frame_err 1-cycle pulse, uart_data_out unchanged; both -> R_IDLE.
REQ-020 uart_data_out SHALL hold its value until the next valid frame completes.
REQ-021 Latency: uart_done SHALL assert within 3 sys_clk cycles of the stop-bit midpoint as seen on the pin.
REQ-022 TX FSM states: T_IDLE, T_SEND.
REQ-023 In T_IDLE, uart_en=1 SHALL latch uart_data_in, set tx_busy next cycle, and start a 10-bit frame (start 0, 8 data, stop 1), each bit BPS_CNT cycles.
REQ-024 uart_en held high over several cycles SHALL start exactly one frame; a new frame requires uart_en sampled high while tx_busy=0.
REQ-025 uart_en while tx_busy=1 SHALL be ignored, no data latched.
REQ-026 tx_busy SHALL clear in the cycle after the stop bit's last cycle; uart_txd SHALL then be high.
REQ-027 RX and TX SHALL be fully independent; simultaneous receive and transmit SHALL both complete correctly.
REQ-028 Bit counters SHALL not wrap mid-frame; the bit index counts 0..9 only.

Reset
REQ-029 While sys_rst_n=0: uart_txd=1, uart_done=0, frame_err=0, tx_busy=0, uart_data_out=8'h00, both FSMs idle, synchronizer flops=1.
REQ-030 Reset asserted mid-frame SHALL abort both directions immediately; no uart_done or frame_err pulse SHALL follow release.
REQ-031 After release, a line already low SHALL not be taken as a start bit until it has been seen high.

Verification (CLK_FREQ=1000000, UART_BPS=100000, BPS_CNT=10)
REQ-032 Drive rxd frame for 8'hA5 -> uart_done single pulse, uart_data_out=8'hA5, frame_err=0.
REQ-033 Pulse uart_en 1 cycle with uart_data_in=8'h3C -> uart_txd shows 0,0,0,1,1,1,1,0,0,1 at 10 cycles/bit; tx_busy high for 100 cycles.
REQ-034 rxd low for 3 cycles then high -> no uart_done, no frame_err, FSM back in R_IDLE.
REQ-035 rxd frame 8'h5A with stop bit low -> frame_err pulse, uart_done stays 0, uart_data_out keeps previous 8'hA5.
REQ-036 uart_en=1 with 8'h11, then uart_en=1 with 8'h22 at cycle 40 -> only 8'h11 transmitted; 8'h22 never appears.
REQ-037 Reset asserted at cycle 50 of a TX frame and mid-RX frame -> uart_txd=1 immediately, no pulses after release, next 8'h0F frame received correctly.
